// File: rtl/cv32e40p_rf_write_arbiter.sv
// Schedules EX / LSU / APU-FIFO writebacks onto the two register-file write ports.
// Optional anti-starvation for the APU FIFO head: define CV32E40P_RF_ARB_STARVE_EN.
module cv32e40p_rf_write_arbiter #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ex_valid_i,
  input  logic [ADDR_WIDTH-1:0]         ex_waddr_i,
  input  logic [DATA_WIDTH-1:0]         ex_wdata_i,
  input  logic                          lsu_valid_i,
  input  logic [ADDR_WIDTH-1:0]         lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0]         lsu_wdata_i,
  output logic                          lsu_ready_o,
  input  logic                          apu_valid_i,
  input  logic [ADDR_WIDTH-1:0]         apu_waddr_i,
  input  logic [DATA_WIDTH-1:0]         apu_wdata_i,
  output logic                          apu_ready_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
  output logic [ADDR_WIDTH-1:0]         waddr_a_o,
  output logic [DATA_WIDTH-1:0]         wdata_a_o,
  output logic                          we_a_o,
  output logic [ADDR_WIDTH-1:0]         waddr_b_o,
  output logic [DATA_WIDTH-1:0]         wdata_b_o,
  output logic                          we_b_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];

  logic                  we_a_q, we_a_d, we_b_q, we_b_d;
  logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_a_d, waddr_b_q, waddr_b_d;
  logic [DATA_WIDTH-1:0] wdata_a_q, wdata_a_d, wdata_b_q, wdata_b_d;

  logic                           push, pop, f_valid, f_prio;
  logic [2:0]                     cand_v, take;
  logic [2:0][ADDR_WIDTH-1:0]     cand_a;
  logic [2:0][DATA_WIDTH-1:0]     cand_d;
  logic [2:0][1:0]                order;
  logic [1:0]                     nsel;
  logic [1:0]                     src;

  assign apu_ready_o = (cnt_q < CW'(FIFO_DEPTH));
  assign push        = apu_valid_i & apu_ready_o;
  assign f_valid     = (cnt_q != '0);
  assign fifo_cnt_o  = cnt_q;

`ifdef CV32E40P_RF_ARB_STARVE_EN
  logic [3:0] starve_q, starve_d;
  assign f_prio = (starve_q == 4'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (!f_valid || pop)                    starve_d = '0;
    else if (starve_q < 4'(STARVE_LIMIT))   starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
`else
  assign f_prio = 1'b0;
`endif

  // Candidate indices: 0 = EX, 1 = LSU, 2 = FIFO head. EX always walks first.
  always_comb begin
    cand_v    = {f_valid, lsu_valid_i, ex_valid_i};
    cand_a    = {mem_addr_q[rd_ptr_q], lsu_waddr_i, ex_waddr_i};
    cand_d    = {mem_data_q[rd_ptr_q], lsu_wdata_i, ex_wdata_i};
    order     = f_prio ? {2'd1, 2'd2, 2'd0} : {2'd2, 2'd1, 2'd0};
    take      = '0;
    nsel      = '0;
    src       = '0;
    we_a_d    = 1'b0;
    waddr_a_d = waddr_a_q;
    wdata_a_d = wdata_a_q;
    we_b_d    = 1'b0;
    waddr_b_d = waddr_b_q;
    wdata_b_d = wdata_b_q;
    for (int k = 0; k < 3; k++) begin
      src = order[k];
      if (cand_v[src]) begin
        // x0 writes are discarded but still count as consumed
        if (cand_a[src] == '0) begin
          take[src] = 1'b1;
        end else if (nsel == 2'd0) begin
          take[src] = 1'b1;
          we_a_d    = 1'b1;
          waddr_a_d = cand_a[src];
          wdata_a_d = cand_d[src];
          nsel      = 2'd1;
        end else if (nsel == 2'd1 && cand_a[src] != waddr_a_d) begin
          take[src] = 1'b1;
          we_b_d    = 1'b1;
          waddr_b_d = cand_a[src];
          wdata_b_d = cand_d[src];
          nsel      = 2'd2;
        end
      end
    end
  end

  assign lsu_ready_o = take[1];
  assign pop         = take[2];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      we_a_q    <= 1'b0;
      waddr_a_q <= '0;
      wdata_a_q <= '0;
      we_b_q    <= 1'b0;
      waddr_b_q <= '0;
      wdata_b_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      we_a_q    <= we_a_d;
      waddr_a_q <= waddr_a_d;
      wdata_a_q <= wdata_a_d;
      we_b_q    <= we_b_d;
      waddr_b_q <= waddr_b_d;
      wdata_b_q <= wdata_b_d;
    end
  end

  // Storage needs no reset: clearing the pointers invalidates every entry.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= apu_waddr_i;
      mem_data_q[wr_ptr_q] <= apu_wdata_i;
    end
  end

  assign we_a_o    = we_a_q;
  assign waddr_a_o = waddr_a_q;
  assign wdata_a_o = wdata_a_q;
  assign we_b_o    = we_b_q;
  assign waddr_b_o = waddr_b_q;
  assign wdata_b_o = wdata_b_q;

endmodule
